// File: rtl/fpga_status_seq.sv
`default_nettype none
// ============================================================================
// Module      : fpga_status_seq
// Description : Board-level status sequencer for one to eight compute cores.
//               After reset release it holds the cores in reset for a fixed
//               number of cycles. It then runs them under a watchdog and
//               latches one terminal outcome: PASS, FAIL or TOUT. The outcome
//               is shown on four status LEDs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NCORES         : number of monitored core channels (1..8)
//   HOLD_CYCLES    : cycles core_reset is held after synchronised release (>=1)
//   TIMEOUT_CYCLES : watchdog limit while running (>=2)
//   BLINK_LOG2     : log2 of heartbeat half-period in cycles
// Ports
//   ph1        in   1       sole clock, rising edge
//   reset      in   1       asynchronous active-low reset
//   pass       in   NCORES  per-core success level
//   fail       in   NCORES  per-core failure level
//   core_reset out  1       active-high reset to the cores
//   leds       out  4       {running, succeeded, failed, power}
//   core_done  out  NCORES  sticky per-core done flags
//   timeout    out  1       watchdog expiry flag
// Build option
//   FPGA_STATUS_HEARTBEAT_EN : when defined, the running LED blinks with a
//                              half-period of 2**BLINK_LOG2 cycles instead of
//                              staying steady.
// ============================================================================
module fpga_status_seq #(
  parameter int unsigned NCORES         = 1,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2**20,
  parameter int unsigned BLINK_LOG2     = 22
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic [NCORES-1:0] pass,
  input  logic [NCORES-1:0] fail,
  output logic              core_reset,
  output logic [3:0]        leds,
  output logic [NCORES-1:0] core_done,
  output logic              timeout
);

  localparam logic [2:0] S_HOLD = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_PASS = 3'd2;
  localparam logic [2:0] S_FAIL = 3'd3;
  localparam logic [2:0] S_TOUT = 3'd4;

  localparam int unsigned     HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned     WD_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        sync_q;
  logic              released;
  logic [2:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [NCORES-1:0] done_q, done_d;
  logic              core_reset_q, core_reset_d;
  logic [3:0]        leds_q, leds_d;
  logic              timeout_q, timeout_d;
  logic              run_led;

  // Reset release is synchronised through two flops. Assertion still acts
  // asynchronously on every register through the reset pin.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign released = sync_q[1];

  // State register, including the counters and sticky done flags.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q <= S_HOLD;
      hold_q  <= '0;
      wd_q    <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Both counters stop at their limit and never wrap,
  // because reaching the limit always forces a state change.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wd_d    = wd_q;
    done_d  = done_q;
    case (state_q)
      S_HOLD: begin
        if (released) begin
          if (hold_q == HOLD_LAST) state_d = S_RUN;
          else                     hold_d  = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        done_d = done_q | pass | fail;
        // Priority: fail, then completion, then watchdog.
        if (|fail)                state_d = S_FAIL;
        else if (&done_d)         state_d = S_PASS;
        else if (wd_q == WD_LAST) state_d = S_TOUT;
        else                      wd_d    = wd_q + 1'b1;
      end
      S_PASS, S_FAIL, S_TOUT: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

`ifdef FPGA_STATUS_HEARTBEAT_EN
  // Free-running phase divider. It restarts at zero on RUN entry, so the LED
  // begins lit. Its top bit gives the blink phase, and rollover is intended.
  logic [BLINK_LOG2:0] blink_q, blink_d;

  always_comb begin
    blink_d = '0;
    if ((state_d == S_RUN) && (state_q == S_RUN)) blink_d = blink_q + 1'b1;
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) blink_q <= '0;
    else        blink_q <= blink_d;
  end

  assign run_led = ~blink_d[BLINK_LOG2];
`else
  assign run_led = 1'b1;
`endif

  // Output logic. It decodes next state, so the registered outputs line up
  // with the state register.
  always_comb begin
    core_reset_d = (state_d != S_RUN);
    timeout_d    = (state_d == S_TOUT);
    leds_d       = {(state_d == S_RUN) & run_led,
                    (state_d == S_PASS),
                    (state_d == S_FAIL) | (state_d == S_TOUT),
                    1'b1};
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      core_reset_q <= 1'b1;
      leds_q       <= 4'b0000;
      timeout_q    <= 1'b0;
    end else begin
      core_reset_q <= core_reset_d;
      leds_q       <= leds_d;
      timeout_q    <= timeout_d;
    end
  end

  assign core_reset = core_reset_q;
  assign leds       = leds_q;
  assign core_done  = done_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire
